clause_stream_memory: RTL and testbench
=======================================

Name: clause_stream_memory

Overview:
Writable clause store for the SAT datapath; successor to the fixed-content static clause memory. Streams NUM_CLAUSES_PER_CYCLE clauses per beat to the evaluation array under valid/ready backpressure. Adds a load port, a programmable active row count, single-pass or looping modes, and start/stop control.

Parameters:
NUM_CLAUSES, 64, total clause capacity; must be a multiple of NUM_CLAUSES_PER_CYCLE
VAR_ID_BITS, 8, variable-id width; literal = {neg, var_id}, VAR_ID_BITS+1 bits
NUM_VARS_PER_CLAUSE, 3, literals per clause
NUM_CLAUSES_PER_CYCLE, 16, clauses per output beat
Derived: LIT_W=VAR_ID_BITS+1, CLAUSE_W=LIT_W*NUM_VARS_PER_CLAUSE, ROWS=NUM_CLAUSES/NUM_CLAUSES_PER_CYCLE, ROW_W=max(1,$clog2(ROWS)), ADDR_W=$clog2(NUM_CLAUSES)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
wr_en  in  1  clause write strobe
wr_addr  in  ADDR_W  clause index
wr_clause  in  CLAUSE_W  clause data; literal 0 in the LSBs
wr_err  out  1  one-cycle pulse when a write is dropped
start  in  1  begin a stream (pulse)
stop  in  1  abort the stream (pulse)
loop_mode  in  1  0 = single pass, 1 = wrap forever; sampled at start
num_rows  in  ROW_W+1  active rows; sampled at start
busy  out  1  high while in STREAM
out_valid  out  1  beat valid
out_ready  in  1  consumer ready
out_slice  out  CLAUSE_W*NUM_CLAUSES_PER_CYCLE  row data; clause k of the row at bits [k*CLAUSE_W +: CLAUSE_W]
out_row  out  ROW_W  row index of the current beat
out_last  out  1  current beat is the final active row
done  out  1  one-cycle pulse when a single pass completes
pass_cnt  out  16  completed passes in loop mode; saturating

Behaviour:
- Reset: all outputs 0, state IDLE. Memory contents are not reset.
- Row r holds clauses r*NUM_CLAUSES_PER_CYCLE .. r*NUM_CLAUSES_PER_CYCLE+NUM_CLAUSES_PER_CYCLE-1.
- States:
  - IDLE: accepts writes and start.
  - STREAM: ignores start; drops writes.
- Writes:
  - A write in IDLE commits at the clock edge and is visible to any later read.
  - Any wr_en in STREAM, or in the same cycle as an accepted start, is dropped; wr_err pulses on the next cycle.
- Start:
  - On start in IDLE, latch loop_mode and n_eff. n_eff = ROWS if num_rows is 0 or greater than ROWS; otherwise n_eff = num_rows.
  - Clear pass_cnt, move to STREAM, set busy.
  - Row 0 is presented with out_valid=1 on the following cycle (1-cycle latency).
- Output registers: out_slice, out_row and out_last hold stable while out_valid && !out_ready.
- Handshake (out_valid && out_ready) on row r < n_eff-1: next cycle presents row r+1 with no bubble.
- Handshake on row n_eff-1:
  - loop_mode=0: out_valid drops next cycle, done pulses, state returns to IDLE, busy drops.
  - loop_mode=1: next cycle presents row 0 and pass_cnt increments, saturating at 0xFFFF.
- out_last = (out_row == n_eff-1). With n_eff=1, every beat has out_last=1.
- Stop in STREAM: out_valid and busy drop next cycle and state returns to IDLE. No done pulse. A beat handshaken in the same cycle as stop counts as delivered. Stop in IDLE has no effect.
- Start and stop in the same cycle in IDLE: start wins. Stop in STREAM has priority over a same-cycle final handshake, so no done pulse.
- Reset asserted mid-stream: immediate return to IDLE; outputs cleared asynchronously.

Optional Feature:
- Macro CLAUSE_STREAM_STALL_CNT_EN.
- Defined: adds output stall_cnt, 32 bits. It counts cycles with out_valid && !out_ready, is cleared by start and by rst, and saturates.
- Undefined: the port and the counter do not exist; all other behaviour is identical.

Decomposition:
- Package sat_pkg holds:
  - LIT_W, CLAUSE_W and ROW helper functions
  - typedef literal_t {logic neg; logic [VAR_ID_BITS-1:0] var_id}
  - typedef clause_t (array of literal_t)
  - enum stream_state_e {IDLE, STREAM}
- One sub-module, clause_row_ram: ROWS x row-width storage with per-clause write enable and a synchronous read. The parent holds the FSM, pointers, handshake logic and counters.

Test Plan:
- Load clause i with all literals = {0, i[7:0]} (i=0..63). Start with num_rows=0, loop_mode=0, out_ready=1 -> 4 beats on consecutive cycles, rows 0..3; beat r clause k var_id = 16r+k; out_last on row 3; done on the cycle after row 3; busy low after.
- Same load, num_rows=2, out_ready toggled 1,0,0,1 -> row 0 accepted, row 1 held stable for 2 cycles, then accepted; done after row 1.
- loop_mode=1, num_rows=3, out_ready=1 for 10 cycles -> rows 0,1,2,0,1,2,0,1,2,0; pass_cnt = 3; no done. Then stop -> out_valid=0 and busy=0 next cycle.
- wr_en during STREAM to clause 5 -> wr_err pulse; next pass shows clause 5 unchanged. wr_en together with start -> dropped, wr_err pulses.
- num_rows=7 (> ROWS=4) -> clamped; out_last on row 3. num_rows=1 -> single beat with out_last=1, then done.
- rst asserted mid-beat with out_ready=0 -> all outputs 0 immediately; a subsequent start streams from row 0. With CLAUSE_STREAM_STALL_CNT_EN, 5 stalled cycles -> stall_cnt=5.

Source files
------------

// File: rtl/sat_pkg.sv
// Shared types, sizing helpers and FSM states for the SAT clause store.
// Ports: none (package).
package sat_pkg;

  localparam int VAR_ID_BITS = 8;
  localparam int NUM_VARS_PER_CLAUSE = 3;

  typedef struct packed {
    logic                   neg;
    logic [VAR_ID_BITS-1:0] var_id;
  } literal_t;

  typedef literal_t [NUM_VARS_PER_CLAUSE-1:0] clause_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } stream_state_e;

  function automatic int lit_w(input int vb);
    return vb + 1;
  endfunction

  function automatic int clause_w(input int vb, input int nv);
    return (vb + 1) * nv;
  endfunction

  function automatic int rows_of(input int nc, input int npc);
    return nc / npc;
  endfunction

  function automatic int row_w(input int r);
    return (r > 1) ? $clog2(r) : 1;
  endfunction

endpackage

// File: rtl/clause_row_ram.sv
// Row-organised clause storage: per-clause write enables, registered read.
// Ports: clk, rst, i_we/i_wrow/i_wdata (write), i_re/i_rrow -> o_rdata (read).
module clause_row_ram #(
  parameter int ROWS     = 4,
  parameter int ROW_W    = 2,
  parameter int CLAUSE_W = 27,
  parameter int NPC      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NPC-1:0]          i_we,
  input  logic [ROW_W-1:0]        i_wrow,
  input  logic [CLAUSE_W-1:0]     i_wdata,
  input  logic                    i_re,
  input  logic [ROW_W-1:0]        i_rrow,
  output logic [CLAUSE_W*NPC-1:0] o_rdata
);

  logic [CLAUSE_W*NPC-1:0] r_mem [ROWS];
  logic [CLAUSE_W*NPC-1:0] r_rdata;

  always_ff @(posedge clk) begin
    for (int k = 0; k < NPC; k++) begin
      if (i_we[k]) begin
        r_mem[i_wrow][k*CLAUSE_W +: CLAUSE_W] <= i_wdata;
      end
    end
  end

  // Read register holds its value while i_re is low, which is what
  // keeps the output beat stable under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_rrow];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/clause_stream_memory.sv
// Writable clause store streaming one row of clauses per valid/ready beat.
// Ports: wr_* load port, start/stop/loop_mode/num_rows control, out_* stream,
// busy/done/pass_cnt status. Macro CLAUSE_STREAM_STALL_CNT_EN adds stall_cnt.
module clause_stream_memory
  import sat_pkg::*;
#(
  parameter int NUM_CLAUSES           = 64,
  parameter int VAR_ID_BITS           = 8,
  parameter int NUM_VARS_PER_CLAUSE   = 3,
  parameter int NUM_CLAUSES_PER_CYCLE = 16,
  localparam int CLAUSE_W = clause_w(VAR_ID_BITS, NUM_VARS_PER_CLAUSE),
  localparam int ROWS     = rows_of(NUM_CLAUSES, NUM_CLAUSES_PER_CYCLE),
  localparam int ROW_W    = row_w(ROWS),
  localparam int ADDR_W   = $clog2(NUM_CLAUSES),
  localparam int SLICE_W  = CLAUSE_W * NUM_CLAUSES_PER_CYCLE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [CLAUSE_W-1:0] wr_clause,
  output logic                wr_err,
  input  logic                start,
  input  logic                stop,
  input  logic                loop_mode,
  input  logic [ROW_W:0]      num_rows,
  output logic                busy,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SLICE_W-1:0]  out_slice,
  output logic [ROW_W-1:0]    out_row,
  output logic                out_last,
  output logic                done,
  output logic [15:0]         pass_cnt
`ifdef CLAUSE_STREAM_STALL_CNT_EN
  ,
  output logic [31:0]         stall_cnt
`endif
);

  localparam int NPC    = NUM_CLAUSES_PER_CYCLE;
  localparam int NEFF_W = ROW_W + 1;

  stream_state_e      r_state, w_nxt_state;
  logic               r_valid, w_nxt_valid;
  logic [ROW_W-1:0]   r_row, w_nxt_row;
  logic               r_last, w_nxt_last;
  logic               r_done, w_nxt_done;
  logic               r_loop, w_nxt_loop;
  logic [NEFF_W-1:0]  r_neff, w_nxt_neff;
  logic [15:0]        r_pass, w_nxt_pass;
  logic               r_wr_err;

  logic               w_hs;
  logic               w_re;
  logic               w_start_acc;
  logic               w_wr_ok;
  logic [NEFF_W-1:0]  w_neff_in;
  logic [ROW_W-1:0]   w_wr_row;
  logic [NPC-1:0]     w_we;
  int                 w_wr_idx;

  assign w_start_acc = (r_state == IDLE) && start;
  assign w_wr_ok     = wr_en && (r_state == IDLE) && !start;
  assign w_hs        = r_valid && out_ready;

  // Zero or oversize row counts select the full memory.
  assign w_neff_in =
    (num_rows == '0 || num_rows > NEFF_W'(ROWS)) ?
    NEFF_W'(ROWS) : num_rows;

  assign w_wr_row = ROW_W'(int'(wr_addr) / NPC);
  assign w_wr_idx = int'(wr_addr) % NPC;
  assign w_we     = w_wr_ok ? (NPC'(1) << w_wr_idx) : '0;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_valid = r_valid;
    w_nxt_row   = r_row;
    w_nxt_last  = r_last;
    w_nxt_done  = 1'b0;
    w_nxt_loop  = r_loop;
    w_nxt_neff  = r_neff;
    w_nxt_pass  = r_pass;
    w_re        = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_nxt_state = STREAM;
          w_nxt_valid = 1'b1;
          w_nxt_row   = '0;
          w_nxt_loop  = loop_mode;
          w_nxt_neff  = w_neff_in;
          w_nxt_last  = (w_neff_in == NEFF_W'(1));
          w_nxt_pass  = '0;
          w_re        = 1'b1;
        end
      end
      STREAM: begin
        if (stop) begin
          w_nxt_state = IDLE;
          w_nxt_valid = 1'b0;
        end else if (w_hs) begin
          if (!r_last) begin
            w_nxt_row  = r_row + ROW_W'(1);
            // Next row is last when r_row+1 == n_eff-1.
            w_nxt_last = (NEFF_W'(r_row) + NEFF_W'(2)) == r_neff;
            w_re       = 1'b1;
          end else if (r_loop) begin
            w_nxt_row  = '0;
            w_nxt_last = (r_neff == NEFF_W'(1));
            w_re       = 1'b1;
            if (r_pass != 16'hFFFF) begin
              w_nxt_pass = r_pass + 16'd1;
            end
          end else begin
            w_nxt_state = IDLE;
            w_nxt_valid = 1'b0;
            w_nxt_done  = 1'b1;
          end
        end
      end
      default: begin
        w_nxt_state = IDLE;
        w_nxt_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_valid  <= 1'b0;
      r_row    <= '0;
      r_last   <= 1'b0;
      r_done   <= 1'b0;
      r_loop   <= 1'b0;
      r_neff   <= '0;
      r_pass   <= '0;
      r_wr_err <= 1'b0;
    end else begin
      r_state  <= w_nxt_state;
      r_valid  <= w_nxt_valid;
      r_row    <= w_nxt_row;
      r_last   <= w_nxt_last;
      r_done   <= w_nxt_done;
      r_loop   <= w_nxt_loop;
      r_neff   <= w_nxt_neff;
      r_pass   <= w_nxt_pass;
      r_wr_err <= wr_en && !w_wr_ok;
    end
  end

`ifdef CLAUSE_STREAM_STALL_CNT_EN
  logic [31:0] r_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall <= '0;
    end else if (w_start_acc) begin
      r_stall <= '0;
    end else if (r_valid && !out_ready && r_stall != '1) begin
      r_stall <= r_stall + 32'd1;
    end
  end

  assign stall_cnt = r_stall;
`endif

  clause_row_ram #(
    .ROWS     (ROWS),
    .ROW_W    (ROW_W),
    .CLAUSE_W (CLAUSE_W),
    .NPC      (NPC)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_wrow  (w_wr_row),
    .i_wdata (wr_clause),
    .i_re    (w_re),
    .i_rrow  (w_nxt_row),
    .o_rdata (out_slice)
  );

  assign wr_err    = r_wr_err;
  assign busy      = (r_state == STREAM);
  assign out_valid = r_valid;
  assign out_row   = r_row;
  assign out_last  = r_last;
  assign done      = r_done;
  assign pass_cnt  = r_pass;

endmodule

// File: tb/tb_clause_stream_memory.sv
// Directed bench for clause_stream_memory with immediate-assertion checks.
// Ports: none. Define CLAUSE_STREAM_STALL_CNT_EN to also check stall_cnt.
module tb_clause_stream_memory;

  localparam int CW = 27;
  localparam int SW = CW * 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [5:0]    wr_addr;
  logic [CW-1:0] wr_clause;
  logic          wr_err;
  logic          start;
  logic          stop;
  logic          loop_mode;
  logic [2:0]    num_rows;
  logic          busy;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] out_slice;
  logic [1:0]    out_row;
  logic          out_last;
  logic          done;
  logic [15:0]   pass_cnt;
`ifdef CLAUSE_STREAM_STALL_CNT_EN
  logic [31:0]   stall_cnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  clause_stream_memory dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_clause (wr_clause),
    .wr_err    (wr_err),
    .start     (start),
    .stop      (stop),
    .loop_mode (loop_mode),
    .num_rows  (num_rows),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_slice (out_slice),
    .out_row   (out_row),
    .out_last  (out_last),
    .done      (done),
    .pass_cnt  (pass_cnt)
`ifdef CLAUSE_STREAM_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  function automatic logic [CW-1:0] cl(input int i);
    logic [8:0] lit;
    lit = {1'b0, 8'(i)};
    return {lit, lit, lit};
  endfunction

  function automatic logic [SW-1:0] exp_row(input int r);
    logic [SW-1:0] v;
    v = '0;
    for (int k = 0; k < 16; k++) begin
      v[k*CW +: CW] = cl(16 * r + k);
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_s(input string tag, input logic [SW-1:0] obs,
                       input logic [SW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input string tag, input int r, input logic lst);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_row"}, 32'(out_row), 32'(r));
    chk({tag, "_last"}, 32'(out_last), 32'(lst));
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk_s({tag, "_slice"}, out_slice, exp_row(r));
  endtask

  initial begin
    rst = 1'b1;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_clause = '0;
    start = 1'b0;
    stop = 1'b0;
    loop_mode = 1'b0;
    num_rows = '0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_wr_err", 32'(wr_err), 32'd0);
    chk("rst_pass", 32'(pass_cnt), 32'd0);
    chk("rst_row", 32'(out_row), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk_s("rst_slice", out_slice, '0);
    rst = 1'b0;

    for (int i = 0; i < 64; i++) begin
      wr_en = 1'b1;
      wr_addr = 6'(i);
      wr_clause = cl(i);
      @(negedge clk);
    end
    wr_en = 1'b0;

    // full single pass, no backpressure
    num_rows = 3'd0;
    loop_mode = 1'b0;
    out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int r = 0; r < 4; r++) begin
      beat("p4", r, r == 3);
      @(negedge clk);
    end
    chk("p4_end_valid", 32'(out_valid), 32'd0);
    chk("p4_end_done", 32'(done), 32'd1);
    chk("p4_end_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("p4_done_pulse", 32'(done), 32'd0);

    // two rows with backpressure on row 1
    num_rows = 3'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    beat("bp_r0", 0, 1'b0);
    @(negedge clk);
    beat("bp_r1a", 1, 1'b1);
    out_ready = 1'b0;
    @(negedge clk);
    beat("bp_r1b", 1, 1'b1);
    @(negedge clk);
    beat("bp_r1c", 1, 1'b1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_end_valid", 32'(out_valid), 32'd0);
    chk("bp_end_done", 32'(done), 32'd1);

    // looping over three rows, then stop
    loop_mode = 1'b1;
    num_rows = 3'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int b = 0; b < 10; b++) begin
      beat("loop", b % 3, (b % 3) == 2);
      chk("loop_pass", 32'(pass_cnt), 32'(b / 3));
      if (b < 9) @(negedge clk);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop_valid", 32'(out_valid), 32'd0);
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_done", 32'(done), 32'd0);
    chk("stop_pass", 32'(pass_cnt), 32'd3);

    // writes colliding with start and with streaming are dropped
    loop_mode = 1'b0;
    num_rows = 3'd0;
    out_ready = 1'b0;
    start = 1'b1;
    wr_en = 1'b1;
    wr_addr = 6'd5;
    wr_clause = '1;
    @(negedge clk);
    start = 1'b0;
    chk("wrs_err", 32'(wr_err), 32'd1);
    beat("wrs_r0", 0, 1'b0);
    @(negedge clk);
    wr_en = 1'b0;
    chk("wrb_err", 32'(wr_err), 32'd1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("wrb_err_pulse", 32'(wr_err), 32'd0);
    chk("wrb_stop_valid", 32'(out_valid), 32'd0);
    chk("wrb_stop_done", 32'(done), 32'd0);
    chk("wrb_stop_busy", 32'(busy), 32'd0);

    // single row: one beat with last, clause 5 unchanged
    num_rows = 3'd1;
    out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    beat("one", 0, 1'b1);
    @(negedge clk);
    chk("one_valid", 32'(out_valid), 32'd0);
    chk("one_done", 32'(done), 32'd1);

    // oversize row count clamps to all rows
    num_rows = 3'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int r = 0; r < 4; r++) begin
      beat("clamp", r, r == 3);
      @(negedge clk);
    end
    chk("clamp_done", 32'(done), 32'd1);
    chk("clamp_valid", 32'(out_valid), 32'd0);

    // reset in the middle of a stalled beat
    out_ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    beat("stall_r0", 0, 1'b0);
`ifdef CLAUSE_STREAM_STALL_CNT_EN
    chk("stall_0", stall_cnt, 32'd0);
    repeat (5) @(negedge clk);
    chk("stall_5", stall_cnt, 32'd5);
    beat("stall_hold", 0, 1'b0);
`endif
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_row", 32'(out_row), 32'd0);
    chk("arst_last", 32'(out_last), 32'd0);
    chk("arst_pass", 32'(pass_cnt), 32'd0);
    chk_s("arst_slice", out_slice, '0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    beat("post_rst", 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
